id_issue_buffer: RTL and testbench
==================================

# id_issue_buffer

Parametrised decode/issue stage register for the 0dMIPS pipeline. It sits between the instruction decoder and EX and replaces the single bubble-on-stall ID register with four pieces of logic:
- a valid/ready elastic 2-entry skid buffer;
- N-way priority operand forwarding;
- an internal load-use scoreboard;
- flush handling.

Data width, forwarding-port count and control-bundle width are parameters, so the same block serves 32- and 64-bit configurations.

## Interface
Parameters:
- XLEN, 64, operand/PC width
- NFWD, 2, forwarding sources; index 0 is the youngest and has the highest priority
- CTRL_W, 128, width of the opaque decoded-control bundle passed through unchanged

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- flush  in  1  kills every instruction held in this block
- in_valid  in  1  decoder has an instruction
- in_ready  out  1  block accepts this cycle
- in_pc  in  XLEN  fetch PC
- in_inst  in  32  raw instruction
- in_ctrl  in  CTRL_W  decoded controls
- in_rs, in_rt  in  5  source register numbers
- in_rs_used, in_rt_used  in  1  source is actually read
- in_wreg  in  5  destination register
- in_wen  in  1  writes a register
- in_is_load  in  1  instruction is a load
- rf_a, rf_b  in  XLEN  register-file read data for in_rs/in_rt (write-before-read file)
- fwd_valid  in  NFWD  forwarding source active
- fwd_regnum  in  NFWD×5  forwarding destination register
- fwd_data  in  NFWD×XLEN  forwarding data
- ld_done_valid  in  1  load result is being written back this cycle
- ld_done_regnum  in  5  register the load writes
- out_valid  out  1  issue slot valid
- out_ready  in  1  EX accepts
- out_pc, out_inst, out_ctrl, out_a, out_b, out_wreg, out_wen, out_is_load  out  same widths as the inputs
- hazard_stall  out  1  accepting is blocked by a load-use hazard this cycle

## Operation
Operand selection, per operand:
- If fwd_valid[i] and fwd_regnum[i]==src and src!=0, take fwd_data[i], lowest i wins.
- Otherwise take the regfile data.
- Register 0 always reads 0.

Load-use hazard:
- hazard = (in_rs_used and pending[in_rs]) or (in_rt_used and pending[in_rt]).
- A source is not hazardous when ld_done_valid and ld_done_regnum matches it in the same cycle; that load's data is on a forwarding port.

Acceptance:
- in_ready = !skid_valid && !hazard && !reset.
- Acceptance fires on in_valid && in_ready.
- Operands are resolved and frozen at acceptance.
- Integration invariant: every older non-load producer is visible on the regfile or a forwarding port when the consumer is accepted.

Scoreboard:
- pending[31:1], one bit per register; pending[0] is hardwired 0.
- Set on issue, i.e. out_valid && out_ready && out_is_load && out_wen && out_wreg!=0.
- Cleared on ld_done_valid for ld_done_regnum.
- If set and clear hit the same register in the same cycle, set wins.

Skid FSM, states EMPTY / ONE / TWO:
- EMPTY: accept → ONE.
- ONE: accept without issue → TWO; issue without accept → EMPTY; accept and issue together → ONE, the output register reloads.
- TWO: issue → ONE, the skid entry moves to the output register; no accept is possible in this state.

Flush:
- Next state is EMPTY and any accept in that cycle is discarded.
- The scoreboard is kept, because issued loads are older than the flush.

## Timing
- Latency from accept to out_valid is 1 cycle. Throughput is 1 per cycle while out_ready=1.
- in_ready is combinational from skid state and hazard only; it never depends on out_ready.
- Outputs are registered; out_* hold stable while out_valid && !out_ready.
- Values after reset:
  - out_valid=0
  - all out_* data=0
  - state EMPTY
  - pending=0
  - in_ready=0 during the reset cycle, 1 after
  - hazard_stall=0
- Reset asserted mid-operation behaves like flush and additionally clears the scoreboard.
- Simultaneous flush and out_ready: the issue still completes, and a load issued in that cycle still sets pending.
- pending never wraps; each register carries a single bit.

## Configuration
- ID_SCOREBOARD_EN defined: the scoreboard and hazard logic are present as described above.
- ID_SCOREBOARD_EN undefined:
  - pending is removed;
  - hazard and hazard_stall are tied to 0;
  - load-use protection falls to the external hazard unit through flush or a deasserted in_valid.

## Structure
- Add to package structures:
  - id_skid_state_t enum {EMPTY, ONE, TWO};
  - localparam REG_ZERO = 5'd0.
- Parametrised fields are not packed into a struct; entries are flat vectors.
- Sub-module id_fwd_mux (params XLEN, NFWD), pure combinational priority select, instantiated twice, for A and B.
- The FSM, the skid/output registers and the scoreboard all live in id_issue_buffer.

## Test plan
- Forwarding priority: fwd0=(r5,0xAA) and fwd1=(r5,0xBB), accept rs=r5 → out_a=0xAA one cycle later; with rs=r0 and fwd0=(r0,0x1) → out_a=0.
- Backpressure: 3 back-to-back accepts with out_ready=0 → accepts 1 and 2 taken, in_ready=0 on the third; out_ready=1 → issues in order with data unchanged.
- Load-use: issue load to r8, then present rt=r8 with rt_used → hazard_stall=1 and in_ready=0 until ld_done(r8); in the ld_done cycle it is accepted with out_b=fwd data.
- Set/clear collision: issue a load to r3 while ld_done(r3) is valid → pending[3]=1 afterwards.
- Flush in TWO: flush=1 with out_ready=0 → out_valid=0 next cycle, pending unchanged.
- Reset in TWO with pending[7]=1 → all outputs 0, pending[7]=0, in_ready=1 the cycle after reset deasserts; repeat with ID_SCOREBOARD_EN undefined → hazard_stall stays 0.

Source files
------------

// File: rtl/id_issue_buffer_pkg.sv
// Shared types and constants for the decode/issue buffer.
// Provides the skid FSM state encoding and register-number helpers.
package id_issue_buffer_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } id_skid_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam int         NREGS    = 32;

    // A source register can match a producer only when it is not r0.
    function automatic logic reg_hit(input logic [4:0] src, input logic [4:0] dst);
        return (src != REG_ZERO) && (src == dst);
    endfunction

endpackage

// File: rtl/id_issue_buffer_fwd_mux.sv
// id_fwd_mux: combinational priority operand select for one source.
// Ports: src_i (register number), rf_data_i (regfile read),
//   fwd_valid_i/fwd_regnum_i/fwd_data_i (flat forwarding sources,
//   index 0 youngest/highest priority), data_o (resolved operand).
module id_fwd_mux
    import id_issue_buffer_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int NFWD = 2
) (
    input  logic [4:0]           src_i,
    input  logic [XLEN-1:0]      rf_data_i,
    input  logic [NFWD-1:0]      fwd_valid_i,
    input  logic [NFWD*5-1:0]    fwd_regnum_i,
    input  logic [NFWD*XLEN-1:0] fwd_data_i,
    output logic [XLEN-1:0]      data_o
);

    always_comb begin
        data_o = rf_data_i;
        // Walk oldest to youngest so the lowest index overrides last.
        for (int i = NFWD - 1; i >= 0; i--) begin
            if (fwd_valid_i[i] && reg_hit(src_i, fwd_regnum_i[i*5 +: 5])) begin
                data_o = fwd_data_i[i*XLEN +: XLEN];
            end
        end
        if (src_i == REG_ZERO) begin
            data_o = '0;
        end
    end

endmodule

// File: rtl/id_issue_buffer.sv
// id_issue_buffer: decode/issue stage register with a 2-entry elastic
// skid buffer, N-way operand forwarding, a load-use scoreboard and flush.
// Ports: clock/reset (sync, active-high), flush; decoder side in_* with
//   in_valid/in_ready; rf_a/rf_b regfile data; fwd_* forwarding sources;
//   ld_done_* load writeback; EX side out_* with out_valid/out_ready;
//   hazard_stall flags a load-use block on acceptance.
// Build option: define ID_SCOREBOARD_EN to include the internal load-use
//   scoreboard; without it hazard_stall is tied low.
module id_issue_buffer
    import id_issue_buffer_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int NFWD   = 2,
    parameter int CTRL_W = 128
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [XLEN-1:0]      in_pc,
    input  logic [31:0]          in_inst,
    input  logic [CTRL_W-1:0]    in_ctrl,
    input  logic [4:0]           in_rs,
    input  logic [4:0]           in_rt,
    input  logic                 in_rs_used,
    input  logic                 in_rt_used,
    input  logic [4:0]           in_wreg,
    input  logic                 in_wen,
    input  logic                 in_is_load,
    input  logic [XLEN-1:0]      rf_a,
    input  logic [XLEN-1:0]      rf_b,
    input  logic [NFWD-1:0]      fwd_valid,
    input  logic [NFWD*5-1:0]    fwd_regnum,
    input  logic [NFWD*XLEN-1:0] fwd_data,
    input  logic                 ld_done_valid,
    input  logic [4:0]           ld_done_regnum,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_pc,
    output logic [31:0]          out_inst,
    output logic [CTRL_W-1:0]    out_ctrl,
    output logic [XLEN-1:0]      out_a,
    output logic [XLEN-1:0]      out_b,
    output logic [4:0]           out_wreg,
    output logic                 out_wen,
    output logic                 out_is_load,
    output logic                 hazard_stall
);

    // Flat entry layout: pc, inst, ctrl, a, b, wreg, wen, is_load.
    localparam int ENT_W = XLEN + 32 + CTRL_W + XLEN + XLEN + 5 + 1 + 1;

    id_skid_state_t   state_q;
    logic             out_valid_q;
    logic [ENT_W-1:0] out_q;
    logic [ENT_W-1:0] skid_q;
    logic [ENT_W-1:0] in_ent_d;

    logic [XLEN-1:0] opa;
    logic [XLEN-1:0] opb;
    logic            hazard;
    logic            skid_valid;
    logic            accept;
    logic            issue;

    id_fwd_mux #(
        .XLEN (XLEN),
        .NFWD (NFWD)
    ) u_fwd_a (
        .src_i        (in_rs),
        .rf_data_i    (rf_a),
        .fwd_valid_i  (fwd_valid),
        .fwd_regnum_i (fwd_regnum),
        .fwd_data_i   (fwd_data),
        .data_o       (opa)
    );

    id_fwd_mux #(
        .XLEN (XLEN),
        .NFWD (NFWD)
    ) u_fwd_b (
        .src_i        (in_rt),
        .rf_data_i    (rf_b),
        .fwd_valid_i  (fwd_valid),
        .fwd_regnum_i (fwd_regnum),
        .fwd_data_i   (fwd_data),
        .data_o       (opb)
    );

    assign in_ent_d = {in_pc, in_inst, in_ctrl, opa, opb,
                       in_wreg, in_wen, in_is_load};

    assign {out_pc, out_inst, out_ctrl, out_a, out_b,
            out_wreg, out_wen, out_is_load} = out_q;

    assign skid_valid   = (state_q == TWO);
    assign in_ready     = !skid_valid && !hazard && !reset;
    assign accept       = in_valid && in_ready;
    assign out_valid    = out_valid_q;
    assign issue        = out_valid_q && out_ready;
    assign hazard_stall = hazard && !reset;

`ifdef ID_SCOREBOARD_EN
    logic [31:1] pend_q;
    logic [31:0] pend_d;
    logic [31:0] pend;
    logic        rs_bypass;
    logic        rt_bypass;

    assign pend = {pend_q, 1'b0};

    // Clear first, then set, so an issuing load wins a same-register race.
    always_comb begin
        pend_d = pend;
        if (ld_done_valid) begin
            pend_d[ld_done_regnum] = 1'b0;
        end
        if (issue && out_is_load && out_wen && (out_wreg != REG_ZERO)) begin
            pend_d[out_wreg] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    // Flush leaves pend_q alone: issued loads are older than the flush.
    always_ff @(posedge clock) begin
        if (reset) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d[31:1];
        end
    end

    // A completing load is already on a forwarding port this cycle.
    assign rs_bypass = ld_done_valid && (ld_done_regnum == in_rs);
    assign rt_bypass = ld_done_valid && (ld_done_regnum == in_rt);

    assign hazard = (in_rs_used && pend[in_rs] && !rs_bypass) ||
                    (in_rt_used && pend[in_rt] && !rt_bypass);
`else
    logic unused_sb;

    assign hazard    = 1'b0;
    assign unused_sb = ^{in_rs_used, in_rt_used,
                         ld_done_valid, ld_done_regnum};
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= EMPTY;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            skid_q      <= '0;
        end else if (flush) begin
            // Any accept in this cycle is dropped with the held entries.
            state_q     <= EMPTY;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        out_q       <= in_ent_d;
                        out_valid_q <= 1'b1;
                        state_q     <= ONE;
                    end
                end
                ONE: begin
                    if (accept && issue) begin
                        out_q <= in_ent_d;
                    end else if (accept) begin
                        skid_q  <= in_ent_d;
                        state_q <= TWO;
                    end else if (issue) begin
                        out_valid_q <= 1'b0;
                        state_q     <= EMPTY;
                    end
                end
                TWO: begin
                    if (issue) begin
                        out_q   <= skid_q;
                        state_q <= ONE;
                    end
                end
                default: begin
                    state_q     <= EMPTY;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_id_issue_buffer.sv
// Scoreboard bench for id_issue_buffer: accepted instructions queue
// their expected issue image; a negedge monitor compares each issue.
module tb_id_issue_buffer;

    localparam int XLEN   = 64;
    localparam int NFWD   = 2;
    localparam int CTRL_W = 128;

`ifdef ID_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    logic                 clock;
    logic                 reset;
    logic                 flush;
    logic                 in_valid;
    logic                 in_ready;
    logic [XLEN-1:0]      in_pc;
    logic [31:0]          in_inst;
    logic [CTRL_W-1:0]    in_ctrl;
    logic [4:0]           in_rs;
    logic [4:0]           in_rt;
    logic                 in_rs_used;
    logic                 in_rt_used;
    logic [4:0]           in_wreg;
    logic                 in_wen;
    logic                 in_is_load;
    logic [XLEN-1:0]      rf_a;
    logic [XLEN-1:0]      rf_b;
    logic [NFWD-1:0]      fwd_valid;
    logic [NFWD*5-1:0]    fwd_regnum;
    logic [NFWD*XLEN-1:0] fwd_data;
    logic                 ld_done_valid;
    logic [4:0]           ld_done_regnum;
    logic                 out_valid;
    logic                 out_ready;
    logic [XLEN-1:0]      out_pc;
    logic [31:0]          out_inst;
    logic [CTRL_W-1:0]    out_ctrl;
    logic [XLEN-1:0]      out_a;
    logic [XLEN-1:0]      out_b;
    logic [4:0]           out_wreg;
    logic                 out_wen;
    logic                 out_is_load;
    logic                 hazard_stall;

    typedef struct {
        logic [XLEN-1:0]   pc;
        logic [31:0]       inst;
        logic [CTRL_W-1:0] ctrl;
        logic [XLEN-1:0]   a;
        logic [XLEN-1:0]   b;
        logic [6:0]        wfl;
    } exp_t;

    exp_t q[$];
    exp_t me;
    int   checks = 0;
    int   errors = 0;

    id_issue_buffer #(
        .XLEN   (XLEN),
        .NFWD   (NFWD),
        .CTRL_W (CTRL_W)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_pc          (in_pc),
        .in_inst        (in_inst),
        .in_ctrl        (in_ctrl),
        .in_rs          (in_rs),
        .in_rt          (in_rt),
        .in_rs_used     (in_rs_used),
        .in_rt_used     (in_rt_used),
        .in_wreg        (in_wreg),
        .in_wen         (in_wen),
        .in_is_load     (in_is_load),
        .rf_a           (rf_a),
        .rf_b           (rf_b),
        .fwd_valid      (fwd_valid),
        .fwd_regnum     (fwd_regnum),
        .fwd_data       (fwd_data),
        .ld_done_valid  (ld_done_valid),
        .ld_done_regnum (ld_done_regnum),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .out_ctrl       (out_ctrl),
        .out_a          (out_a),
        .out_b          (out_b),
        .out_wreg       (out_wreg),
        .out_wen        (out_wen),
        .out_is_load    (out_is_load),
        .hazard_stall   (hazard_stall)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [CTRL_W-1:0] act,
                       input logic [CTRL_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [XLEN-1:0] pc,
                                input logic [XLEN-1:0] a,
                                input logic [XLEN-1:0] b,
                                input logic [4:0] wreg,
                                input logic wen, input logic ld);
        exp_t e;
        e.pc   = pc;
        e.inst = pc[31:0] ^ 32'h1234_5678;
        e.ctrl = {~pc, pc};
        e.a    = a;
        e.b    = b;
        e.wfl  = {wreg, wen, ld};
        return e;
    endfunction

    task automatic set_in(input logic [XLEN-1:0] pc,
                          input logic [4:0] rs, input logic [4:0] rt,
                          input logic rsu, input logic rtu,
                          input logic [4:0] wreg, input logic wen,
                          input logic ld,
                          input logic [XLEN-1:0] ra,
                          input logic [XLEN-1:0] rb);
        in_pc      = pc;
        in_inst    = pc[31:0] ^ 32'h1234_5678;
        in_ctrl    = {~pc, pc};
        in_rs      = rs;
        in_rt      = rt;
        in_rs_used = rsu;
        in_rt_used = rtu;
        in_wreg    = wreg;
        in_wen     = wen;
        in_is_load = ld;
        rf_a       = ra;
        rf_b       = rb;
    endtask

    // Present the driven instruction until taken; returns at posedge+1.
    task automatic accept(input exp_t e);
        in_valid = 1'b1;
        for (int n = 0; n < 30; n++) begin
            @(negedge clock);
            if (in_ready) begin
                q.push_back(e);
                @(posedge clock);
                #1;
                in_valid = 1'b0;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL accept_timeout: got in_ready 0 expected 1 for pc %0h", e.pc);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 40; n++) begin
            @(negedge clock);
            if (q.size() == 0) begin
                @(posedge clock);
                #1;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
        q.delete();
    endtask

    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_issue: got pc %0h expected none", out_pc);
            end else begin
                me = q.pop_front();
                chk("out_pc", out_pc, me.pc);
                chk("out_inst", out_inst, me.inst);
                chk("out_ctrl", out_ctrl, me.ctrl);
                chk("out_a", out_a, me.a);
                chk("out_b", out_b, me.b);
                chk("out_wflags", {out_wreg, out_wen, out_is_load}, me.wfl);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        fwd_valid = '0; fwd_regnum = '0; fwd_data = '0;
        ld_done_valid = 1'b0; ld_done_regnum = '0;
        set_in('0, 0, 0, 0, 0, 0, 0, 0, '0, '0);

        // Reset values
        @(negedge clock);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_hazard", hazard_stall, 0);
        @(negedge clock);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_out_ab", {out_a, out_b}, 0);
        chk("rst_out_ctrl", out_ctrl, 0);
        chk("rst_out_w", {out_inst, out_wreg, out_wen, out_is_load}, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        chk("post_rst_in_ready", in_ready, 1);
        @(posedge clock); #1;

        // Forwarding priority and r0
        out_ready  = 1'b1;
        fwd_valid  = 2'b11;
        fwd_regnum = {5'd5, 5'd5};
        fwd_data   = {64'hBB, 64'hAA};
        set_in(64'h100, 5, 6, 1, 1, 1, 1, 0, 64'h11, 64'h66);
        accept(mk(64'h100, 64'hAA, 64'h66, 1, 1, 0));
        fwd_data = '1;
        @(negedge clock);
        chk("latency_valid", out_valid, 1);
        @(posedge clock); #1;
        fwd_valid  = 2'b01;
        fwd_regnum = {5'd0, 5'd0};
        fwd_data   = {64'h0, 64'h1};
        set_in(64'h104, 0, 0, 1, 1, 2, 1, 0, 64'h77, 64'h88);
        accept(mk(64'h104, 64'h0, 64'h0, 2, 1, 0));
        fwd_valid  = 2'b10;
        fwd_regnum = {5'd9, 5'd9};
        fwd_data   = {64'hBB, 64'hCC};
        set_in(64'h108, 9, 10, 1, 1, 3, 0, 0, 64'h11, 64'h22);
        accept(mk(64'h108, 64'hBB, 64'h22, 3, 0, 0));
        fwd_valid  = 2'b11;
        fwd_regnum = {5'd10, 5'd9};
        fwd_data   = {64'hDD, 64'hCC};
        set_in(64'h10C, 9, 10, 1, 1, 4, 1, 0, 64'h11, 64'h22);
        accept(mk(64'h10C, 64'hCC, 64'hDD, 4, 1, 0));
        fwd_valid = '0;
        drain();

        // Backpressure: two taken, third blocked until drain
        out_ready = 1'b0;
        set_in(64'h200, 1, 2, 0, 0, 5, 1, 0, 64'hA0, 64'hB0);
        in_valid = 1'b1;
        @(negedge clock);
        chk("bp_ready1", in_ready, 1);
        q.push_back(mk(64'h200, 64'hA0, 64'hB0, 5, 1, 0));
        @(posedge clock); #1;
        set_in(64'h204, 1, 2, 0, 0, 6, 1, 0, 64'hA1, 64'hB1);
        @(negedge clock);
        chk("bp_ready2", in_ready, 1);
        q.push_back(mk(64'h204, 64'hA1, 64'hB1, 6, 1, 0));
        @(posedge clock); #1;
        set_in(64'h208, 1, 2, 0, 0, 7, 1, 0, 64'hA2, 64'hB2);
        @(negedge clock);
        chk("bp_ready3", in_ready, 0);
        chk("bp_hold1", out_pc, 64'h200);
        @(negedge clock);
        chk("bp_hold2", {out_valid, out_a}, {1'b1, 64'hA0});
        @(posedge clock); #1;
        out_ready = 1'b1;
        accept(mk(64'h208, 64'hA2, 64'hB2, 7, 1, 0));
        drain();

        // Load-use on rt
        set_in(64'h300, 0, 0, 0, 0, 8, 1, 1, '0, '0);
        accept(mk(64'h300, 64'h0, 64'h0, 8, 1, 1));
        drain();
        set_in(64'h304, 1, 8, 0, 1, 4, 1, 0, 64'h31, 64'h38);
        in_valid = 1'b1;
`ifdef ID_SCOREBOARD_EN
        @(negedge clock);
        chk("lu_stall", {hazard_stall, in_ready}, 2'b10);
        @(negedge clock);
        chk("lu_stall2", {hazard_stall, in_ready}, 2'b10);
        @(posedge clock); #1;
        ld_done_valid  = 1'b1;
        ld_done_regnum = 5'd8;
        fwd_valid      = 2'b01;
        fwd_regnum     = {5'd0, 5'd8};
        fwd_data       = {64'h0, 64'h88};
        @(negedge clock);
        chk("lu_release", {hazard_stall, in_ready}, 2'b01);
        q.push_back(mk(64'h304, 64'h31, 64'h88, 4, 1, 0));
`else
        @(negedge clock);
        chk("lu_nostall", {hazard_stall, in_ready}, 2'b01);
        q.push_back(mk(64'h304, 64'h31, 64'h38, 4, 1, 0));
`endif
        @(posedge clock); #1;
        in_valid = 1'b0; ld_done_valid = 1'b0; fwd_valid = '0;
        drain();

        // Set/clear collision on r3
        out_ready = 1'b0;
        set_in(64'h400, 0, 0, 0, 0, 3, 1, 1, '0, '0);
        accept(mk(64'h400, 64'h0, 64'h0, 3, 1, 1));
        ld_done_valid  = 1'b1;
        ld_done_regnum = 5'd3;
        out_ready      = 1'b1;
        @(negedge clock);
        @(posedge clock); #1;
        ld_done_valid = 1'b0;
        out_ready     = 1'b0;
        set_in(64'h404, 3, 0, 1, 0, 1, 1, 0, '0, '0);
        @(negedge clock);
        chk("coll_pending", hazard_stall, SB);
        @(posedge clock); #1;
        ld_done_valid  = 1'b1;
        ld_done_regnum = 5'd3;
        @(negedge clock);
        chk("coll_bypass", hazard_stall, 0);
        @(posedge clock); #1;
        ld_done_valid = 1'b0;
        @(negedge clock);
        chk("coll_cleared", hazard_stall, 0);
        @(posedge clock); #1;

        // Flush in TWO keeps pending[7]
        out_ready = 1'b1;
        set_in(64'h500, 0, 0, 0, 0, 7, 1, 1, '0, '0);
        accept(mk(64'h500, 64'h0, 64'h0, 7, 1, 1));
        drain();
        out_ready = 1'b0;
        set_in(64'h504, 0, 0, 0, 0, 1, 1, 0, 64'h5, 64'h6);
        accept(mk(64'h504, 64'h5, 64'h6, 1, 1, 0));
        set_in(64'h508, 0, 0, 0, 0, 1, 1, 0, 64'h5, 64'h6);
        accept(mk(64'h508, 64'h5, 64'h6, 1, 1, 0));
        @(negedge clock);
        chk("two_full", {out_valid, in_ready}, 2'b10);
        @(posedge clock); #1;
        flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0;
        q.delete();
        in_rs = 5'd7; in_rs_used = 1'b1;
        @(negedge clock);
        chk("flush_valid", out_valid, 0);
        chk("flush_pending", {hazard_stall, in_ready}, {SB, !SB});
        @(posedge clock); #1;

        // Reset in TWO clears pending[7]
        set_in(64'h600, 0, 0, 0, 0, 2, 1, 0, 64'h61, 64'h62);
        accept(mk(64'h600, 64'h61, 64'h62, 2, 1, 0));
        set_in(64'h604, 0, 0, 0, 0, 2, 1, 0, 64'h63, 64'h64);
        accept(mk(64'h604, 64'h63, 64'h64, 2, 1, 0));
        reset = 1'b1;
        in_rs = 5'd7; in_rs_used = 1'b1;
        @(negedge clock);
        chk("mid_rst_ready", in_ready, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        q.delete();
        @(negedge clock);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_data", {out_pc, out_a}, 0);
        chk("mid_rst_ctrl", out_ctrl, 0);
        chk("mid_rst_haz", {hazard_stall, in_ready}, 2'b01);
        @(posedge clock); #1;

        // Normal operation resumes
        out_ready = 1'b1;
        set_in(64'h700, 7, 0, 1, 0, 9, 1, 0, 64'h71, 64'h72);
        accept(mk(64'h700, 64'h71, 64'h0, 9, 1, 0));
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
